adder_sweep_checker: RTL
========================

Name: adder_sweep_checker

Overview:
On-chip exhaustive stimulus generator and response checker for an N-bit unsigned adder with a carry-out, such as three_bit_adder.
- On start, drives every (a, b) pair in order: a outer loop, b inner loop, both 0..2^N-1.
- Waits a settle interval per vector, then compares the DUT's {carry, sum} against a+b.
- Reports pass/fail, the error count and the first failing vector.
- Sits beside the adder in FPGA builds, replacing the simulation-only display sweep with self-checking hardware.

Parameters:
- N, 3, operand width in bits (N >= 1).
- SETTLE_CYCLES, 1, cycles each vector is held before checking (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a sweep.
- a  output  N  operand A to the DUT.
- b  output  N  operand B to the DUT.
- dut_out  input  N+1  DUT result, {carry_out, sum}.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid when done; 1 iff error_count == 0.
- error_count  output  2N+1  number of mismatching vectors in the last sweep.
- first_fail_a  output  N  a of the first mismatch; 0 if none.
- first_fail_b  output  N  b of the first mismatch; 0 if none.
- first_fail_out  output  N+1  dut_out captured at the first mismatch; 0 if none.

Behaviour:
Reset (asynchronous assert, synchronous release):
- State goes to IDLE.
- a, b, busy, done, pass, error_count, first_fail_* and the settle counter all go to 0.

States: IDLE, DRIVE, CHECK, DONE.

IDLE / DONE:
- On start=1: a=0, b=0, error_count=0, first_fail_*=0, done=0, pass=0, busy=1, settle counter=0; go to DRIVE.
- Otherwise hold. In DONE, done and pass stay stable.

DRIVE:
- a and b are held constant.
- Settle counter increments each cycle.
- After SETTLE_CYCLES cycles in DRIVE, go to CHECK.

CHECK (exactly 1 cycle; a and b still held):
- Expected value = zero-extend(a) + zero-extend(b), N+1 bits, no truncation.
- On mismatch: error_count increments. If this is the first mismatch of the sweep, capture a, b and dut_out into first_fail_*.
- If a == 2^N-1 and b == 2^N-1: go to DONE; busy=0, done=1, pass=(final error_count == 0).
- Else if b == 2^N-1: b=0, a=a+1. Otherwise b=b+1. Clear the settle counter and go to DRIVE.

Timing and boundary rules:
- Sweep latency: 2^(2N)*(SETTLE_CYCLES+1) cycles from the first DRIVE cycle to the last CHECK cycle.
- done rises on the next edge. For N=3, SETTLE_CYCLES=1 that is 128 cycles, then done.
- start while busy is ignored; it causes no restart and no counter change.
- start in DONE launches a new sweep and clears done on that edge.
- error_count maximum is 2^(2N); it fits in 2N+1 bits and never wraps.
- Reset mid-sweep aborts immediately to the reset values. No partial result is retained.
- Unknown or X values on dut_out count as mismatches in simulation.

Decomposition:
- Package adder_check_pkg holds the state enum (IDLE, DRIVE, CHECK, DONE) and the default N and SETTLE_CYCLES constants.
- One natural sub-module, vector_counter. It is a 2N-bit operand counter with clear, advance and a last-vector flag; {a, b} is its value with a in the high bits.
- Expected-sum computation and the compare stay inline.

Test Plan:
1. Correct behavioural adder model, N=3, SETTLE=1: pulse start → busy high for 128 cycles; done=1, pass=1, error_count=0, first_fail_*=0. (a, b) visits 000/000, 000/001, …, 111/111 in order.
2. Adder with carry_out stuck-at-0 → error_count=28 (pairs with a+b ≥ 8), pass=0, first_fail_a=001, first_fail_b=111, first_fail_out=0000.
3. Adder with sum bit 0 stuck-at-1 → error_count=32, first_fail_a=000, first_fail_b=000, first_fail_out=0001.
4. Reset asserted asynchronously mid-sweep (vector 20) → all outputs 0 the same cycle, without a clock edge. A new start then completes a full 128-cycle sweep with pass=1.
5. Repeated start pulses while busy → no effect; completion still at cycle 128. A second start in DONE clears done and error_count and reruns the sweep.
6. SETTLE_CYCLES=3 with a DUT model delayed by 2 cycles → pass=1 after 256 cycles. The same DUT with SETTLE_CYCLES=1 → pass=0.

Source files
------------

// File: rtl/adder_check_pkg.sv
// adder_check_pkg: shared state encoding and default sizing for the adder sweep checker
package adder_check_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
  localparam int N_DEF = 3;
  localparam int SETTLE_DEF = 1;
endpackage

// File: rtl/vector_counter.sv
// vector_counter: operand-pair counter, {a, b} with a in the high bits, flags the all-ones vector
module vector_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] value,
  output logic         last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (clr) value <= '0;
    else if (adv) value <= value + 1'b1;
  assign last = &value;
endmodule

// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: exhaustive (a, b) sweep of an N-bit adder, checking {carry, sum} against a+b
module adder_sweep_checker
  import adder_check_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  input  logic [N:0]   dut_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [2*N:0] error_count,
  output logic [N-1:0] first_fail_a,
  output logic [N-1:0] first_fail_b,
  output logic [N:0]   first_fail_out
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [2*N-1:0] vec;
  logic [N:0] sum_exp;
  logic mis, last, clr, adv;
  vector_counter #(.W(2 * N)) u_vec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .adv   (adv),
    .value (vec),
    .last  (last)
  );
  assign a = vec[2*N-1:N];
  assign b = vec[N-1:0];
  assign sum_exp = {1'b0, a} + {1'b0, b};
  // case equality so an X/Z result is a mismatch in simulation
  assign mis = !(dut_out === sum_exp);
  assign busy = state == DRIVE || state == CHECK;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    clr = 1'b0;
    adv = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        clr = 1'b1;
      end
      DRIVE: if (cnt == CW'(SETTLE_CYCLES - 1)) state_d = CHECK;
      CHECK: begin
        state_d = last ? DONE : DRIVE;
        adv = !last;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || clr) begin
      cnt <= '0;
      pass <= 1'b0;
      error_count <= '0;
      first_fail_a <= '0;
      first_fail_b <= '0;
      first_fail_out <= '0;
    end else if (state == DRIVE) cnt <= cnt + 1'b1;
    else if (state == CHECK) begin
      cnt <= '0;
      if (mis) error_count <= error_count + 1'b1;
      if (mis && error_count == '0) begin
        first_fail_a <= a;
        first_fail_b <= b;
        first_fail_out <= dut_out;
      end
      if (last) pass <= !mis && error_count == '0;
    end
endmodule
